speculoos_call_observer: RTL and testbench

Upstream decode stage of the Speculoos shadow-stack monitor. Samples each instruction retired by the mor1kx cappuccino pipeline and classifies it as a call (l.jal, optionally l.jalr) or a return (l.jr r9). For a call it computes the expected return address; for a return it captures the jump target. It pushes each event into a small FIFO, which the monitor drains through a valid/ready handshake, so pipeline bursts never drop events silently.

---
 rtl/speculoos_call_observer.sv | 170 +++++++++++++++++
 tb/tb_speculoos_call_observer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/speculoos_call_observer.sv
// speculoos_call_observer: classifies retired l.jal / l.jr r9 (and l.jalr when SPECULOOS_JALR_TRACK_EN is defined) into call/return events.
// Latency: an event retired at edge N is at the FIFO head right after edge N when the FIFO was empty; one push and one pop per cycle.
// Backpressure: valid/ready on the event port; a push into a full FIFO with no same-cycle pop is dropped and overflow_o latches.
module speculoos_call_observer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  insn_valid_i,
    input  logic [31:0]           insn_i,
    input  logic [31:0]           address_i,
    input  logic [31:0]           jr_target_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic                  evt_kind_o,
    output logic [31:0]           evt_addr_o,
    output logic [DEPTH_LOG2:0]   evt_count_o,
    output logic                  overflow_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Occupancy constants sized to the count register.
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // OpenRISC 1000 opcodes of interest and the link register.
    localparam logic [5:0]  OPC_JAL  = 6'h01;
    localparam logic [5:0]  OPC_JR   = 6'h11;
    localparam logic [4:0]  LINK_REG = 5'd9;
`ifdef SPECULOOS_JALR_TRACK_EN
    localparam logic [5:0]  OPC_JALR = 6'h12;
`endif

    // A call returns past the jump and its delay slot.
    localparam logic [31:0] CALL_RET_OFFSET = 32'd8;

    typedef struct packed {
        logic        kind;   // 1 = call, 0 = return
        logic [31:0] addr;
    } evt_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] reg_b;
    logic       is_jal;
    logic       is_jalr;
    logic       is_ret;

    assign opcode = insn_i[31:26];
    assign reg_b  = insn_i[15:11];
    assign is_jal = (opcode == OPC_JAL);
    assign is_ret = (opcode == OPC_JR) && (reg_b == LINK_REG);

`ifdef SPECULOOS_JALR_TRACK_EN
    assign is_jalr = (opcode == OPC_JALR);
`else
    // Indirect calls are not tracked in this build; no decode for them.
    assign is_jalr = 1'b0;
`endif

    // Instruction fields the classifier never looks at.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{insn_i[25:16], insn_i[10:0]};

    logic push_vld;
    evt_t push_evt;

    // Build the candidate event for the retired instruction, if any.
    always_comb begin
        push_vld = 1'b0;
        push_evt = '0;
        if (insn_valid_i) begin
            if (is_jal || is_jalr) begin
                push_vld      = 1'b1;
                push_evt.kind = 1'b1;
                push_evt.addr = address_i + CALL_RET_OFFSET;
            end else if (is_ret) begin
                push_vld      = 1'b1;
                push_evt.kind = 1'b0;
                push_evt.addr = jr_target_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    evt_t                  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic full;
    logic pop;
    logic push_acc;

    assign full = (count_q == CNT_FULL);
    assign pop  = evt_valid_o && evt_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc = push_vld && (!full || pop);

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (push_vld && !push_acc) begin
            overflow_d = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_acc) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head fields are a plain read of the array at rd_ptr.
    // ------------------------------------------------------------------
    evt_t head;

    assign head        = mem_q[rd_ptr_q];
    assign evt_valid_o = (count_q != '0);
    assign evt_kind_o  = head.kind;
    assign evt_addr_o  = head.addr;
    assign evt_count_o = count_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_speculoos_call_observer.sv
module tb_speculoos_call_observer;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                insn_valid_i;
    logic [31:0]         insn_i;
    logic [31:0]         address_i;
    logic [31:0]         jr_target_i;
    logic                evt_valid_o;
    logic                evt_ready_i;
    logic                evt_kind_o;
    logic [31:0]         evt_addr_o;
    logic [DEPTH_LOG2:0] evt_count_o;
    logic                overflow_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of {kind, addr} plus sticky overflow.
    logic [32:0] model_q[$];
    bit          model_ovf;

    always #5 clk = ~clk;

    speculoos_call_observer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk          (clk),
        .reset        (reset),
        .insn_valid_i (insn_valid_i),
        .insn_i       (insn_i),
        .address_i    (address_i),
        .jr_target_i  (jr_target_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_kind_o   (evt_kind_o),
        .evt_addr_o   (evt_addr_o),
        .evt_count_o  (evt_count_o),
        .overflow_o   (overflow_o)
    );

    // 0 = ignored, 1 = call, 2 = return
    function automatic int classify(input logic [31:0] insn);
        int op;
        int rb;
        op = int'(insn >> 26);
        rb = int'((insn >> 11) & 32'h1F);
        if (op == 1) return 1;
`ifdef SPECULOOS_JALR_TRACK_EN
        if (op == 18) return 1;
`endif
        if (op == 17 && rb == 9) return 2;
        return 0;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at the negedge.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] insn,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic rdy);
        int          kind;
        int          sz;
        bit          popping;
        logic [32:0] e;
        reset        = rst;
        insn_valid_i = v;
        insn_i       = insn;
        address_i    = pc;
        jr_target_i  = tgt;
        evt_ready_i  = rdy;
        @(posedge clk);
        kind    = v ? classify(insn) : 0;
        sz      = model_q.size();
        popping = (sz > 0) && rdy;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (popping) void'(model_q.pop_front());
            if (kind != 0) begin
                e = (kind == 1) ? {1'b1, pc + 32'd8} : {1'b0, tgt};
                if (sz < DEPTH || popping) model_q.push_back(e);
                else model_ovf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 32'h0400_0000, 32'h0000_0123, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h4400_4800, 32'h0000_0456, 32'h55, 1'b0);
        vectors++;
        if (evt_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", evt_valid_o); end
        vectors++;
        if (evt_count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", evt_count_o); end
        vectors++;
        if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %0b want 0", overflow_o); end
        vectors++;
        if ({evt_kind_o, evt_addr_o} !== 33'h0) begin
            miscompares++; $display("FAIL reset_head got %0b/%h want 0/00000000", evt_kind_o, evt_addr_o);
        end
    endtask

    task automatic test_jal_basic();
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0400_0010, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0);
        vectors++;
        if ({evt_valid_o, evt_kind_o, evt_addr_o, evt_count_o} !== {1'b1, 1'b1, 32'h0000_2008, 3'd1}) begin
            miscompares++;
            $display("FAIL jal_head got v=%0b k=%0b a=%h c=%0d want v=1 k=1 a=00002008 c=1",
                     evt_valid_o, evt_kind_o, evt_addr_o, evt_count_o);
        end
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        vectors++;
        if ({evt_valid_o, evt_count_o} !== {1'b0, 3'd0}) begin
            miscompares++; $display("FAIL jal_pop got v=%0b c=%0d want v=0 c=0", evt_valid_o, evt_count_o);
        end
    endtask

    task automatic test_jr_filter();
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h4400_4800, 32'h0000_3000, 32'h0000_2008, 1'b0);
        cycle(1'b0, 1'b1, 32'h4400_1800, 32'h0000_3010, 32'h0000_BEEF, 1'b0);
        vectors++;
        if ({evt_count_o, evt_kind_o, evt_addr_o} !== {3'd1, 1'b0, 32'h0000_2008}) begin
            miscompares++;
            $display("FAIL jr_r9 got c=%0d k=%0b a=%h want c=1 k=0 a=00002008", evt_count_o, evt_kind_o, evt_addr_o);
        end
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        vectors++;
        if (evt_count_o !== 3'd0) begin miscompares++; $display("FAIL jr_r3_ignored got c=%0d want 0", evt_count_o); end
    endtask

    task automatic test_overflow();
        logic [31:0] want;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 32'h0400_0000, 32'(i * 32'h100), 32'h0, 1'b0);
        vectors++;
        if ({evt_count_o, overflow_o} !== {3'd4, 1'b1}) begin
            miscompares++; $display("FAIL ovf_full got c=%0d o=%0b want c=4 o=1", evt_count_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            want = 32'h108 + 32'(i) * 32'h100;
            vectors++;
            if ({evt_valid_o, evt_addr_o} !== {1'b1, want}) begin
                miscompares++; $display("FAIL ovf_drain%0d got v=%0b a=%h want v=1 a=%h", i, evt_valid_o, evt_addr_o, want);
            end
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end
        vectors++;
        if ({evt_count_o, overflow_o} !== {3'd0, 1'b1}) begin
            miscompares++; $display("FAIL ovf_sticky got c=%0d o=%0b want c=0 o=1", evt_count_o, overflow_o);
        end
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        vectors++;
        if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %0b want 0", overflow_o); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] want;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 32'h0400_0000, 32'(i * 32'h1000), 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0400_0000, 32'h0000_5000, 32'h0, 1'b1);
        vectors++;
        if ({evt_count_o, overflow_o} !== {3'd4, 1'b0}) begin
            miscompares++; $display("FAIL fullpp_count got c=%0d o=%0b want c=4 o=0", evt_count_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            want = 32'h2008 + 32'(i) * 32'h1000;
            vectors++;
            if (evt_addr_o !== want) begin
                miscompares++; $display("FAIL fullpp_order%0d got %h want %h", i, evt_addr_o, want);
            end
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_wrap_and_jalr();
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h07FF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b0);
        vectors++;
        if ({evt_kind_o, evt_addr_o} !== {1'b1, 32'h0000_0004}) begin
            miscompares++; $display("FAIL wrap_addr got k=%0b a=%h want k=1 a=00000004", evt_kind_o, evt_addr_o);
        end
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h4800_4800, 32'h0000_3000, 32'h0000_7777, 1'b0);
`ifdef SPECULOOS_JALR_TRACK_EN
        vectors++;
        if ({evt_count_o, evt_kind_o, evt_addr_o} !== {3'd1, 1'b1, 32'h0000_3008}) begin
            miscompares++;
            $display("FAIL jalr got c=%0d k=%0b a=%h want c=1 k=1 a=00003008", evt_count_o, evt_kind_o, evt_addr_o);
        end
`else
        vectors++;
        if (evt_count_o !== 3'd0) begin miscompares++; $display("FAIL jalr_ignored got c=%0d want 0", evt_count_o); end
`endif
    endtask

    task automatic test_reset_midop();
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 32'h0400_0000, 32'(i * 32'h40), 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        vectors++;
        if ({evt_count_o, overflow_o} !== {3'd3, 1'b1}) begin
            miscompares++; $display("FAIL midrst_pre got c=%0d o=%0b want c=3 o=1", evt_count_o, overflow_o);
        end
        cycle(1'b1, 1'b1, 32'h0400_0000, 32'h0000_9000, 32'h0, 1'b0);
        vectors++;
        if ({evt_count_o, evt_valid_o, overflow_o} !== {3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst got c=%0d v=%0b o=%0b want c=0 v=0 o=0", evt_count_o, evt_valid_o, overflow_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] insn;
        logic        rdy;
        logic        rst;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0:       insn = {6'h01, r[25:0]};
                1:       insn = {6'h11, r[25:16], 5'd9, r[10:0]};
                2:       insn = {6'h11, r[25:0]};
                3:       insn = {6'h12, r[25:0]};
                default: insn = r;
            endcase
            rdy = (c < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
            cycle(rst, ($urandom_range(0, 9) < 7), insn, $urandom, $urandom, rdy);
            vectors++;
            if (evt_valid_o !== (model_q.size() > 0)) begin
                miscompares++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, evt_valid_o, model_q.size() > 0);
            end
            vectors++;
            if (evt_count_o !== (DEPTH_LOG2 + 1)'(model_q.size())) begin
                miscompares++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, evt_count_o, model_q.size());
            end
            vectors++;
            if (overflow_o !== model_ovf) begin
                miscompares++; $display("FAIL rnd_ovf cyc %0d got %0b want %0b", c, overflow_o, model_ovf);
            end
            if (model_q.size() > 0) begin
                vectors++;
                if ({evt_kind_o, evt_addr_o} !== model_q[0]) begin
                    miscompares++;
                    $display("FAIL rnd_head cyc %0d got %0b/%h want %0b/%h", c, evt_kind_o, evt_addr_o,
                             model_q[0][32], model_q[0][31:0]);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        insn_valid_i = 1'b0;
        insn_i       = '0;
        address_i    = '0;
        jr_target_i  = '0;
        evt_ready_i  = 1'b0;
        model_ovf    = 1'b0;
        test_reset();
        test_jal_basic();
        test_jr_filter();
        test_overflow();
        test_full_push_pop();
        test_wrap_and_jalr();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
